// File: rtl/fb_pkg.sv
// Shared constants and types for the frame-buffer RAM arbiter slice.
package fb_pkg;
  localparam int FB_PIXELS = 76800;
  localparam int FB_ADDR_W = 19;
  localparam int FB_DATA_W = 8;

  localparam logic PORT_A = 1'b0;
  localparam logic PORT_B = 1'b1;

  typedef enum logic {ST_INIT, ST_RUN} fb_state_t;

  typedef struct packed {
    logic valid;
    logic port;
  } fb_tag_t;
endpackage

// File: rtl/fb_rd_tag_pipe.sv
// Read-return tag delay line: carries {valid, port} and a force-zero flag
// alongside the RAM read latency; synchronous flush empties it.
module fb_rd_tag_pipe import fb_pkg::*; #(
  parameter int DEPTH = 2
) (
  input  logic    clock,
  input  logic    reset,
  input  logic    flush,
  input  fb_tag_t tag_in,
  input  logic    zero_in,
  output fb_tag_t tag_out,
  output logic    zero_out
);
  fb_tag_t          tag_q [DEPTH];
  logic [DEPTH-1:0] zero_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) tag_q[i] <= '0;
      zero_q <= '0;
    end else if (flush) begin
      for (int i = 0; i < DEPTH; i++) tag_q[i] <= '0;
      zero_q <= '0;
    end else begin
      tag_q[0]  <= tag_in;
      zero_q[0] <= zero_in;
      for (int i = 1; i < DEPTH; i++) begin
        tag_q[i]  <= tag_q[i-1];
        zero_q[i] <= zero_q[i-1];
      end
    end
  end

  assign tag_out  = tag_q[DEPTH-1];
  assign zero_out = zero_q[DEPTH-1];
endmodule

// File: rtl/fb_ram_arbiter.sv
// Shares the init-loaded frame-buffer RAM between a high-priority display
// reader (A) and a read/write port (B) with a starvation guard for B.
module fb_ram_arbiter import fb_pkg::*; #(
  parameter int ADDR_W       = FB_ADDR_W,
  parameter int DATA_W       = FB_DATA_W,
  parameter int PIXELS       = FB_PIXELS,
  parameter int READ_LATENCY = 2,
  parameter int STARVE_LIMIT = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              init_done,
  input  logic              a_req,
  input  logic [ADDR_W-1:0] a_addr,
  output logic              a_gnt,
  output logic              a_rvalid,
  output logic [DATA_W-1:0] a_rdata,
  input  logic              b_req,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic              b_gnt,
  output logic              b_rvalid,
  output logic [DATA_W-1:0] b_rdata,
  output logic              b_err,
  output logic [ADDR_W-1:0] ram_address,
  output logic [DATA_W-1:0] ram_data,
  output logic              ram_wren,
  input  logic [DATA_W-1:0] ram_q
);
  localparam int                CNT_W    = $clog2(STARVE_LIMIT + 1);
  localparam logic [ADDR_W-1:0] ADDR_LIM = ADDR_W'(PIXELS);
  localparam logic [CNT_W-1:0]  CNT_MAX  = CNT_W'(STARVE_LIMIT);

  fb_state_t         state_q, state_nxt;
  logic              run, flush, a_win, b_win;
  logic              a_in_range, b_in_range;
  logic [CNT_W-1:0]  starve_cnt;
  fb_tag_t           iss_tag, ret_tag;
  logic              iss_zero, ret_zero;
  logic [DATA_W-1:0] a_rdata_q, b_rdata_q, ret_dat;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state_q <= ST_INIT;
    else        state_q <= state_nxt;
  end

  // Grants are also gated by init_done so nothing is accepted in the
  // cycle whose reads the flush would drop.
  always_comb begin
    state_nxt = state_q;
    run       = 1'b0;
    a_win     = 1'b0;
    b_win     = 1'b0;
    case (state_q)
      ST_INIT: if (init_done)  state_nxt = ST_RUN;
      ST_RUN:  if (!init_done) state_nxt = ST_INIT;
      default: state_nxt = ST_INIT;
    endcase
    run   = (state_q == ST_RUN) && init_done;
    a_win = run && a_req && !(b_req && (starve_cnt == CNT_MAX));
    b_win = run && b_req && !a_win;
  end

  assign flush      = (state_nxt == ST_INIT);
  assign a_gnt      = a_win;
  assign b_gnt      = b_win;
  assign a_in_range = (a_addr < ADDR_LIM);
  assign b_in_range = (b_addr < ADDR_LIM);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      starve_cnt  <= '0;
      ram_address <= '0;
      ram_data    <= '0;
      ram_wren    <= 1'b0;
      b_err       <= 1'b0;
      iss_tag     <= '0;
      iss_zero    <= 1'b0;
    end else begin
      ram_wren <= 1'b0;
      b_err    <= 1'b0;
      iss_tag  <= '0;
      iss_zero <= 1'b0;

      if (!run || b_win || !b_req) starve_cnt <= '0;
      else if (a_win && starve_cnt != CNT_MAX) starve_cnt <= starve_cnt + 1'b1;

      if (flush) begin
        iss_tag <= '0;
      end else if (a_win) begin
        // Out-of-range display reads still return (as zero) to keep timing fixed.
        iss_tag  <= '{valid: 1'b1, port: PORT_A};
        iss_zero <= !a_in_range;
        if (a_in_range) ram_address <= a_addr;
      end else if (b_win) begin
        if (!b_in_range) begin
          b_err <= 1'b1;
        end else begin
          ram_address <= b_addr;
          if (b_we) begin
            ram_data <= b_wdata;
            ram_wren <= 1'b1;
          end else begin
            iss_tag <= '{valid: 1'b1, port: PORT_B};
          end
        end
      end
    end
  end

  fb_rd_tag_pipe #(.DEPTH(READ_LATENCY)) u_tag_pipe (
    .clock    (clock),
    .reset    (reset),
    .flush    (flush),
    .tag_in   (iss_tag),
    .zero_in  (iss_zero),
    .tag_out  (ret_tag),
    .zero_out (ret_zero)
  );

  assign ret_dat  = ret_zero ? '0 : ram_q;
  assign a_rvalid = ret_tag.valid && (ret_tag.port == PORT_A);
  assign b_rvalid = ret_tag.valid && (ret_tag.port == PORT_B);
  assign a_rdata  = a_rvalid ? ret_dat : a_rdata_q;
  assign b_rdata  = b_rvalid ? ret_dat : b_rdata_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      a_rdata_q <= '0;
      b_rdata_q <= '0;
    end else begin
      if (a_rvalid) a_rdata_q <= ret_dat;
      if (b_rvalid) b_rdata_q <= ret_dat;
    end
  end
endmodule
